// File: rtl/conv_pkg.sv
// Shared types for the convolution pipeline, including the pooling/spiking stage.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: default-geometry vector/feature-map types, pool FSM states, spike event record.
package conv_pkg;

  localparam int CONV_COORD_W = 8;
  localparam int CONV_CHANNELS = 4;
  localparam int CONV_NEURON_W = 8;

  // Pixel coordinate pair at the pipeline's default geometry.
  typedef struct packed {
    logic [CONV_COORD_W-1:0] x;
    logic [CONV_COORD_W-1:0] y;
  } vec2_t;

  // One BRAM word: all channels of a single pixel, channel 0 in the low bits.
  typedef logic [CONV_CHANNELS-1:0][CONV_NEURON_W-1:0] feature_map_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    EMIT  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } pool_state_t;

  typedef struct packed {
    logic [CONV_COORD_W-1:0]  x;
    logic [CONV_COORD_W-1:0]  y;
    logic [CONV_CHANNELS-1:0] spikes;
  } spike_event_t;

endpackage

// File: rtl/pool_window_accum.sv
// 2x2 window datapath: holds the four captured pixels, sums each channel, compares to threshold, builds writeback.
// Latency: capture/clear/eval take effect at the next edge; spike_now and wr_dat are combinational.
// Backpressure: none; fully strobed by the pool FSM.
// Ports: clk, rst | clear (zero sums), cap_vld/cap_idx/cap_dat (store pixel, add into sums),
//        eval (latch spike_now into spike_q), wr_idx -> wr_dat (reset/leaked value of that pixel).
module pool_window_accum #(
  parameter int OUT_CHANNELS    = 4,
  parameter int BITS_PER_NEURON = 8,
  parameter int THRESHOLD       = 64,
  parameter int LEAK_SHIFT      = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clear,
  input  logic                                    cap_vld,
  input  logic [1:0]                              cap_idx,
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] cap_dat,
  input  logic                                    eval,
  input  logic [1:0]                              wr_idx,
  output logic [OUT_CHANNELS-1:0]                 spike_now,
  output logic [OUT_CHANNELS-1:0]                 spike_q,
  output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] wr_dat
);

  localparam int BN = BITS_PER_NEURON;
  // Two guard bits hold the sum of four values without overflow.
  localparam int SW = BN + 2;
  localparam logic signed [SW-1:0] THR = SW'(THRESHOLD);

  logic [3:0][OUT_CHANNELS*BN-1:0] pix_q, pix_d;
  logic [OUT_CHANNELS-1:0][SW-1:0] sum_q, sum_d;
  logic [OUT_CHANNELS-1:0]         spike_d;

  // Arithmetic shift rounds toward -inf, so v - (v >>> n) moves toward zero and cannot overflow.
  function automatic logic [BN-1:0] leak(input logic signed [BN-1:0] v);
    if (LEAK_SHIFT == 0) return v;
    return v - (v >>> LEAK_SHIFT);
  endfunction

  always_comb begin
    pix_d   = pix_q;
    sum_d   = sum_q;
    spike_d = spike_q;
    if (clear) sum_d = '0;
    if (cap_vld) begin
      pix_d[cap_idx] = cap_dat;
      for (int c = 0; c < OUT_CHANNELS; c++) begin
        sum_d[c] = sum_q[c] + {{2{cap_dat[c*BN+BN-1]}}, cap_dat[c*BN +: BN]};
      end
    end
    if (eval) spike_d = spike_now;
  end

  always_comb begin
    spike_now = '0;
    wr_dat    = '0;
    for (int c = 0; c < OUT_CHANNELS; c++) begin
      spike_now[c] = $signed(sum_q[c]) >= THR;
      wr_dat[c*BN +: BN] = spike_q[c] ? '0 : leak(pix_q[wr_idx][c*BN +: BN]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q   <= '0;
      sum_q   <= '0;
      spike_q <= '0;
    end else begin
      pix_q   <= pix_d;
      sum_q   <= sum_d;
      spike_q <= spike_d;
    end
  end

endmodule

// File: rtl/pool_unit.sv
// Pooling/spiking stage: sweeps the feature-map BRAM in 2x2 windows, emits spike events, writes back reset/leaked values.
// Latency: 10 cycles per window (4 read, wait, eval, 4 write) plus the EMIT handshake when a channel spikes.
// Backpressure: evt_ready low holds EMIT with fields stable and no BRAM access; the sweep resumes on accept.
// Ports: clk/rst, start/busy/done control; read_req/coord_get/data_out and write_req/coord_wtr/data_in
//        BRAM pool ports (coord = {x,y}, data_out valid the cycle after read_req); evt_* spike event stream.
module pool_unit
  import conv_pkg::*;
#(
  parameter int BITS_PER_COORDINATE = 8,
  parameter int OUT_CHANNELS        = 4,
  parameter int BITS_PER_NEURON     = 8,
  parameter int IMG_WIDTH           = 32,
  parameter int IMG_HEIGHT          = 32,
  parameter int THRESHOLD           = 64,
  parameter int LEAK_SHIFT          = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    read_req,
  output logic [2*BITS_PER_COORDINATE-1:0]        coord_get,
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] data_out,
  output logic                                    write_req,
  output logic [2*BITS_PER_COORDINATE-1:0]        coord_wtr,
  output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] data_in,
  output logic                                    evt_valid,
  input  logic                                    evt_ready,
  output logic [BITS_PER_COORDINATE-1:0]          evt_x,
  output logic [BITS_PER_COORDINATE-1:0]          evt_y,
  output logic [OUT_CHANNELS-1:0]                 evt_spikes
);

  localparam int BC = BITS_PER_COORDINATE;
  // Floor division drops an odd trailing column/row entirely.
  localparam logic [BC-1:0] WX_LAST = BC'(IMG_WIDTH / 2 - 1);
  localparam logic [BC-1:0] WY_LAST = BC'(IMG_HEIGHT / 2 - 1);

  pool_state_t   state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [BC-1:0] wx_q, wx_d, wy_q, wy_d;

  logic [BC-1:0] px, py;
  logic          acc_clear, acc_cap, acc_eval;
  logic [1:0]    acc_cap_idx;
  logic [OUT_CHANNELS-1:0] spike_now, spike_q;
  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] wr_dat;

  // Pixel k of the window: bit 0 selects the odd column, bit 1 the odd row.
  assign px = BC'({wx_q, k_q[0]});
  assign py = BC'({wy_q, k_q[1]});

  pool_window_accum #(
    .OUT_CHANNELS    (OUT_CHANNELS),
    .BITS_PER_NEURON (BITS_PER_NEURON),
    .THRESHOLD       (THRESHOLD),
    .LEAK_SHIFT      (LEAK_SHIFT)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear),
    .cap_vld   (acc_cap),
    .cap_idx   (acc_cap_idx),
    .cap_dat   (data_out),
    .eval      (acc_eval),
    .wr_idx    (k_q),
    .spike_now (spike_now),
    .spike_q   (spike_q),
    .wr_dat    (wr_dat)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wx_d        = wx_q;
    wy_d        = wy_q;
    busy        = 1'b0;
    done        = 1'b0;
    read_req    = 1'b0;
    coord_get   = '0;
    write_req   = 1'b0;
    coord_wtr   = '0;
    data_in     = '0;
    evt_valid   = 1'b0;
    evt_x       = '0;
    evt_y       = '0;
    evt_spikes  = '0;
    acc_clear   = 1'b0;
    acc_cap     = 1'b0;
    acc_cap_idx = '0;
    acc_eval    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          k_d     = '0;
          wx_d    = '0;
          wy_d    = '0;
        end
      end
      READ: begin
        busy      = 1'b1;
        read_req  = 1'b1;
        coord_get = {px, py};
        // Read data lags the request by one cycle, so cycle k stores pixel k-1.
        acc_clear   = (k_q == 2'd0);
        acc_cap     = (k_q != 2'd0);
        acc_cap_idx = k_q - 2'd1;
        k_d         = k_q + 2'd1;
        if (k_q == 2'd3) state_d = WAIT;
      end
      WAIT: begin
        busy        = 1'b1;
        acc_cap     = 1'b1;
        acc_cap_idx = 2'd3;
        state_d     = EVAL;
      end
      EVAL: begin
        busy     = 1'b1;
        acc_eval = 1'b1;
        state_d  = (|spike_now) ? EMIT : WRITE;
      end
      EMIT: begin
        busy       = 1'b1;
        evt_valid  = 1'b1;
        evt_x      = wx_q;
        evt_y      = wy_q;
        evt_spikes = spike_q;
        if (evt_ready) state_d = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        write_req = 1'b1;
        coord_wtr = {px, py};
        data_in   = wr_dat;
        k_d       = k_q + 2'd1;
        if (k_q == 2'd3) begin
          if (wx_q == WX_LAST && wy_q == WY_LAST) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            if (wx_q == WX_LAST) begin
              wx_d = '0;
              wy_d = wy_q + 1'b1;
            end else begin
              wx_d = wx_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end

endmodule

// File: tb/tb_pool_unit.sv
module tb_pool_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // ---------------- instance A: 4x4, 2 channels ----------------
  logic        start = 1'b0;
  logic        busy, done, read_req, write_req, evt_valid;
  logic        evt_ready = 1'b1;
  logic [15:0] coord_get, coord_wtr, data_in;
  logic [15:0] data_out = '0;
  logic [7:0]  evt_x, evt_y;
  logic [1:0]  evt_spikes;

  pool_unit #(
    .BITS_PER_COORDINATE(8), .OUT_CHANNELS(2), .BITS_PER_NEURON(8),
    .IMG_WIDTH(4), .IMG_HEIGHT(4), .THRESHOLD(20), .LEAK_SHIFT(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .read_req(read_req), .coord_get(coord_get), .data_out(data_out),
    .write_req(write_req), .coord_wtr(coord_wtr), .data_in(data_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_x(evt_x), .evt_y(evt_y), .evt_spikes(evt_spikes)
  );

  // ---------------- instance B: 5x3 odd image ----------------
  logic        start_b = 1'b0;
  logic        busy_b, done_b, read_req_b, write_req_b, evt_valid_b;
  logic        evt_ready_b = 1'b1;
  logic [15:0] coord_get_b, coord_wtr_b, data_in_b;
  logic [15:0] data_out_b = '0;
  logic [7:0]  evt_x_b, evt_y_b;
  logic [1:0]  evt_spikes_b;

  pool_unit #(
    .BITS_PER_COORDINATE(8), .OUT_CHANNELS(2), .BITS_PER_NEURON(8),
    .IMG_WIDTH(5), .IMG_HEIGHT(3), .THRESHOLD(20), .LEAK_SHIFT(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .read_req(read_req_b), .coord_get(coord_get_b), .data_out(data_out_b),
    .write_req(write_req_b), .coord_wtr(coord_wtr_b), .data_in(data_in_b),
    .evt_valid(evt_valid_b), .evt_ready(evt_ready_b),
    .evt_x(evt_x_b), .evt_y(evt_y_b), .evt_spikes(evt_spikes_b)
  );

  // ---------------- BRAM model and monitors ----------------
  logic signed [7:0] mem [0:4][0:4][0:1];
  logic        pre_vld = 1'b0;
  logic [2:0]  pre_x = '0, pre_y = '0;
  logic signed [7:0] pre_c0 = '0, pre_c1 = '0;
  logic [2:0]  rx, ry, wx, wy;
  assign rx = coord_get[10:8];
  assign ry = coord_get[2:0];
  assign wx = coord_wtr[10:8];
  assign wy = coord_wtr[2:0];

  int rd_cnt = 0, wr_cnt = 0, nz_cnt = 0, both_cnt = 0, emit_acc = 0, ev_cnt = 0;
  logic [7:0] ev_x [0:15];
  logic [7:0] ev_y [0:15];
  logic [1:0] ev_m [0:15];
  int rd_b = 0, wr_b = 0, bad_b = 0;

  always @(posedge clk) begin
    if (pre_vld) begin
      mem[pre_x][pre_y][0] <= pre_c0;
      mem[pre_x][pre_y][1] <= pre_c1;
    end
    if (read_req) begin
      rd_cnt   <= rd_cnt + 1;
      data_out <= {mem[rx][ry][1], mem[rx][ry][0]};
    end
    if (write_req) begin
      wr_cnt <= wr_cnt + 1;
      mem[wx][wy][0] <= data_in[7:0];
      mem[wx][wy][1] <= data_in[15:8];
      if (data_in != 16'd0) nz_cnt <= nz_cnt + 1;
    end
    if (read_req && write_req) both_cnt <= both_cnt + 1;
    if (evt_valid && (read_req || write_req)) emit_acc <= emit_acc + 1;
    if (evt_valid && evt_ready) begin
      ev_x[ev_cnt[3:0]] <= evt_x;
      ev_y[ev_cnt[3:0]] <= evt_y;
      ev_m[ev_cnt[3:0]] <= evt_spikes;
      ev_cnt <= ev_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (read_req_b) rd_b <= rd_b + 1;
    if (write_req_b) wr_b <= wr_b + 1;
    if ((read_req_b && (coord_get_b[15:8] >= 8'd4 || coord_get_b[7:0] >= 8'd2)) ||
        (write_req_b && (coord_wtr_b[15:8] >= 8'd4 || coord_wtr_b[7:0] >= 8'd2)))
      bad_b <= bad_b + 1;
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic load(input int x, input int y, input int c0, input int c1);
    pre_x  = 3'(x);
    pre_y  = 3'(y);
    pre_c0 = 8'(c0);
    pre_c1 = 8'(c1);
    pre_vld = 1'b1;
    @(posedge clk);
    #1 pre_vld = 1'b0;
  endtask

  task automatic load_win(input int wxi, input int wyi, input int c0, input int c1);
    for (int k = 0; k < 4; k++) load(2*wxi + (k % 2), 2*wyi + (k / 2), c0, c1);
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 16; i++) load(i % 4, i / 4, 0, 0);
  endtask

  // Start at cycle 0; cycle n is observed #1 after the n-th following edge.
  // While stalling, the emitted event must equal (sx,sy,sm) and no BRAM access may occur.
  task automatic sweep_a(input int stall, input int sx, input int sy, input int sm,
                         output int done_cyc);
    int cyc;
    int left;
    logic hs_prev;
    left = stall;
    done_cyc = -1;
    hs_prev = 1'b0;
    evt_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (hs_prev) check("evt_valid_drop", evt_valid, 0);
      hs_prev = 1'b0;
      if (evt_valid && left > 0) begin
        check("stall_evt_x", evt_x, sx);
        check("stall_evt_y", evt_y, sy);
        check("stall_evt_mask", evt_spikes, sm);
        check("stall_no_bram", read_req | write_req, 0);
        evt_ready = 1'b0;
        left--;
      end else begin
        evt_ready = 1'b1;
        if (evt_valid) hs_prev = 1'b1;
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
        break;
      end
      @(posedge clk);
      #1 cyc++;
    end
    evt_ready = 1'b1;
  endtask

  int dc, rd0, wr0, nz0, ev0, cyc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_read_req", read_req, 0);
    check("rst_write_req", write_req, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // All-zero map: 16 reads, 16 zero writes, no events, done at cycle 41.
    fill_zero();
    rd0 = rd_cnt; wr0 = wr_cnt; nz0 = nz_cnt; ev0 = ev_cnt;
    sweep_a(0, 0, 0, 0, dc);
    check("zero_done_cycle", dc, 41);
    check("zero_reads", rd_cnt - rd0, 16);
    check("zero_writes", wr_cnt - wr0, 16);
    check("zero_nonzero_writes", nz_cnt - nz0, 0);
    check("zero_events", ev_cnt - ev0, 0);

    // Mixed windows: (0,0) both spike, (1,0) ch0 only, (0,1) negative, (1,1) ch0 exactly at threshold.
    fill_zero();
    load_win(0, 0, 6, 10);
    load_win(1, 0, 6, 4);
    load_win(0, 1, -8, 0);
    load_win(1, 1, 5, -3);
    ev0 = ev_cnt;
    sweep_a(0, 0, 0, 0, dc);
    check("mix_done_cycle", dc, 44);
    check("mix_events", ev_cnt - ev0, 3);
    check("ev0_x", ev_x[ev0], 0);
    check("ev0_y", ev_y[ev0], 0);
    check("ev0_mask", ev_m[ev0], 3);
    check("ev1_x", ev_x[ev0+1], 1);
    check("ev1_y", ev_y[ev0+1], 0);
    check("ev1_mask", ev_m[ev0+1], 1);
    check("ev2_x", ev_x[ev0+2], 1);
    check("ev2_y", ev_y[ev0+2], 1);
    check("ev2_mask", ev_m[ev0+2], 1);
    check("wb00_ch0", mem[0][0][0], 0);
    check("wb11_ch1", mem[1][1][1], 0);
    check("wb31_ch0", mem[3][1][0], 0);
    check("wb31_ch1", mem[3][1][1], 2);
    check("wb20_ch1", mem[2][0][1], 2);
    check("wb13_neg_ch0", mem[1][3][0], -4);
    check("wb02_ch1", mem[0][2][1], 0);
    check("wb33_thr_ch0", mem[3][3][0], 0);
    check("wb33_ch1", mem[3][3][1], -1);

    // Backpressure: ready low 5 cycles in EMIT of window (0,0).
    fill_zero();
    load_win(0, 0, 6, 10);
    ev0 = ev_cnt;
    sweep_a(5, 0, 0, 3, dc);
    check("stall_done_cycle", dc, 47);
    check("stall_events", ev_cnt - ev0, 1);
    check("stall_ev_mask", ev_m[ev0], 3);
    check("no_rd_wr_overlap", both_cnt, 0);
    check("no_bram_in_emit", emit_acc, 0);

    // Reset during the last READ cycle of the first window, then a normal sweep.
    fill_zero();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    while (cyc < 4) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("pre_rst_read_req", read_req, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_read_req", read_req, 0);
    check("abort_coord_get", coord_get, 0);
    check("abort_write_req", write_req, 0);
    check("abort_evt_valid", evt_valid, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    sweep_a(0, 0, 0, 0, dc);
    check("after_rst_done_cycle", dc, 41);
    check("after_rst_reads", rd_cnt - rd0, 16);
    check("after_rst_writes", wr_cnt - wr0, 16);

    // Odd 5x3 image: two windows, x=4 and y=2 never touched, done at cycle 21.
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    cyc = 1;
    dc = -1;
    while (cyc < 200) begin
      if (done_b) begin
        dc = cyc;
        break;
      end
      @(posedge clk);
      #1 cyc++;
    end
    check("odd_done_cycle", dc, 21);
    check("odd_reads", rd_b, 8);
    check("odd_writes", wr_b, 8);
    check("odd_out_of_scope", bad_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
